// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_arb
// Purpose : Round-robin, message-locked arbiter sharing one UART transmitter.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_arb #(
    parameter int N       = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [N-1:0]   req_valid_i,
    input  logic [8*N-1:0] req_data_i,
    input  logic [N-1:0]   req_last_i,
    output logic [N-1:0]   req_ready_o,
    output logic [N-1:0]   grant_o,
    output logic           uart_wr_o,
    output logic [7:0]     uart_dat_o,
    input  logic           uart_bsy_i,
    output logic           timeout_o
);
    localparam int c_iw = $clog2(N);
    localparam int c_cw = $clog2(TIMEOUT + 1);
    localparam logic [c_cw-1:0] c_timeout = c_cw'(TIMEOUT);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_send   = 2'd1;
    localparam logic [1:0] c_guard1 = 2'd2;
    localparam logic [1:0] c_guard2 = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [c_iw-1:0] owner_q, owner_d;
    logic [c_iw-1:0] last_q, last_d;
    logic [c_cw-1:0] cnt_q, cnt_d;
    logic            lastflag_q, lastflag_d;
    logic            wr_q, wr_d;
    logic [7:0]      dat_q, dat_d;
    logic            timeout_q, timeout_d;

    logic            w_found;
    logic [c_iw-1:0] w_pick;
    logic [c_iw-1:0] w_cand;
    logic            w_owner_valid;
    logic            w_accept;
    logic [c_cw-1:0] w_cnt_inc;
    logic            w_expire;

    // Search starts just past the previous owner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int i = 1; i <= N; i++) begin
            w_cand = c_iw'((int'(last_q) + i) % N);
            if (!w_found && req_valid_i[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    assign w_owner_valid = req_valid_i[owner_q];
    assign w_accept      = (state_q == c_send) & w_owner_valid & ~uart_bsy_i;
    assign w_cnt_inc     = cnt_q + c_cw'(1);
    // A busy UART freezes the counter; only an absent owner can expire the lock.
    assign w_expire      = (state_q == c_send) & ~w_owner_valid & (w_cnt_inc == c_timeout);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= c_idle;
            owner_q    <= '0;
            last_q     <= c_iw'(N - 1);
            cnt_q      <= '0;
            lastflag_q <= 1'b0;
            wr_q       <= 1'b0;
            dat_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            lastflag_q <= lastflag_d;
            wr_q       <= wr_d;
            dat_q      <= dat_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_idle:   if (w_found) state_d = c_send;
            c_send: begin
                if (w_accept)      state_d = c_guard1;
                else if (w_expire) state_d = c_idle;
            end
            c_guard1: state_d = c_guard2;
            c_guard2: state_d = lastflag_q ? c_idle : c_send;
            default:  state_d = c_idle;
        endcase
    end

    always_comb begin
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        lastflag_d = lastflag_q;
        wr_d       = 1'b0;
        dat_d      = dat_q;
        timeout_d  = 1'b0;
        case (state_q)
            c_idle: if (w_found) owner_d = w_pick;
            c_send: begin
                if (w_accept) begin
                    dat_d      = req_data_i[{owner_q, 3'b000} +: 8];
                    wr_d       = 1'b1;
                    lastflag_d = req_last_i[owner_q];
                    cnt_d      = '0;
                end else if (w_expire) begin
                    timeout_d = 1'b1;
                    last_d    = owner_q;
                    cnt_d     = '0;
                end else if (!w_owner_valid) begin
                    cnt_d = w_cnt_inc;
                end
            end
            c_guard2: if (lastflag_q) last_d = owner_q;
            default: ;
        endcase
    end

    always_comb begin
        grant_o     = '0;
        req_ready_o = '0;
        if (state_q != c_idle) grant_o[owner_q] = 1'b1;
        if (state_q == c_send) req_ready_o[owner_q] = w_accept;
    end

    assign uart_wr_o  = wr_q;
    assign uart_dat_o = dat_q;
    assign timeout_o  = timeout_q;

endmodule
`default_nettype wire
